// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: oversampled SPI mode-0 slave that returns a latched joystick snapshot and captures the command byte
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int BITS = FRAME_BYTES * 8;
  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS);
  localparam logic [CW-1:0] CMD_BITS = CW'(8);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic ss_d1_q, sclk_d1_q, first_q, armed_q, armed_d;
  logic [38:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d, cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] led_q, led_d;
  logic miso_q, miso_d, valid_q, valid_d, err_q, err_d;
  logic ss_s, sclk_s, mosi_s, ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [39:0] snap;
  assign ss_s = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall = ss_d1_q & ~ss_s;
  assign ss_rise = ~ss_d1_q & ss_s;
  assign sclk_rise = ~sclk_d1_q & sclk_s;
  assign sclk_fall = sclk_d1_q & ~sclk_s;
  assign snap = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons};
  assign MISO = miso_q;
  assign led = led_q;
  assign cmd_byte = cmd_q;
  assign cmd_valid = valid_q;
  assign frame_err = err_q;
  assign busy = state_q == ACTIVE;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    led_d = led_q;
    miso_d = miso_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    armed_d = armed_q | (~first_q & ss_sync_q[0]);
    if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (ss_fall && armed_q) begin
        state_d = ACTIVE;
        tx_d = snap[38:0];
        miso_d = snap[39];
        cnt_d = '0;
      end
    end else if (ss_rise) begin
      state_d = IDLE;
      miso_d = 1'b0;
      valid_d = cnt_q == LAST;
      err_d = cnt_q != LAST;
      cmd_d = valid_d ? rx_q : cmd_q;
      led_d = (valid_d && rx_q[7]) ? rx_q[1:0] : led_q;
    end else begin
      if (sclk_rise && cnt_q != LAST) begin
        cnt_d = cnt_q + 1'b1;
        rx_d = (cnt_q < CMD_BITS) ? {rx_q[6:0], mosi_s} : rx_q;
      end
      if (sclk_fall && cnt_q == LAST) miso_d = 1'b0;
      else if (sclk_fall && cnt_q != '0) begin
        tx_d = {tx_q[37:0], 1'b0};
        miso_d = tx_q[38];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_q <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_d1_q <= 1'b1;
      sclk_d1_q <= 1'b0;
      first_q <= 1'b1;
      armed_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
      cmd_q <= '0;
      led_q <= '0;
      miso_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ss_sync_q <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_d1_q <= ss_s;
      sclk_d1_q <= sclk_s;
      first_q <= 1'b0;
      armed_q <= armed_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      led_q <= led_d;
      miso_q <= miso_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: table, directed and randomized frames checked against a byte-level joystick model
module tb_jstk_spi_responder;
  localparam int H = 8;
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
    logic [7:0] cmd;
    int nbits;
    logic [39:0] exp_frame;
    logic [7:0] exp_cmd;
    logic [1:0] exp_led;
    int exp_valid;
    int exp_err;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, SS = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic [9:0] x_pos = '0, y_pos = '0;
  logic [2:0] buttons = '0;
  logic MISO, cmd_valid, frame_err, busy;
  logic [1:0] led;
  logic [7:0] cmd_byte;
  int passed = 0, total = 0, n_valid = 0, n_err = 0, n_both = 0;
  logic [7:0] m_cmd = '0;
  logic [1:0] m_led = '0;
  vec_t vecs[6];
  always #5 clk = ~clk;
  jstk_spi_responder dut (
    .clk(clk), .rst(rst), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .led(led),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .frame_err(frame_err), .busy(busy)
  );
  always @(negedge clk) begin
    if (cmd_valid) n_valid++;
    if (frame_err) n_err++;
    if (cmd_valid && frame_err) n_both++;
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask
  function automatic logic [39:0] ref_frame(input int x, input int y, input int b);
    int bytes[5];
    logic [39:0] f;
    bytes = '{x % 256, x / 256, y % 256, y / 256, b};
    f = '0;
    foreach (bytes[k]) f = (f << 8) | 40'(bytes[k]);
    return f;
  endfunction
  task automatic spi_frame(input logic [7:0] cmd, input int nbits, output logic [63:0] got, output logic busy_seen);
    logic [39:0] tx;
    tx = {cmd, 32'h0};
    got = '0;
    @(negedge clk) SS = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 40) ? tx[39-i] : 1'b0;
      repeat (H) @(negedge clk);
      got[63-i] = MISO;
      SCLK = 1'b1;
      repeat (H) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (H) @(negedge clk);
    busy_seen = busy;
    SS = 1'b1;
    MOSI = 1'b0;
    repeat (H + 6) @(negedge clk);
  endtask
  task automatic check_frame(input string name, input logic [63:0] got, input logic bs, input int v0, input int e0,
                             input logic [39:0] exp_frame, input int nbits, input logic [7:0] exp_cmd,
                             input logic [1:0] exp_led, input int exp_valid, input int exp_err);
    logic [63:0] mask;
    mask = (nbits == 0) ? 64'h0 : ~64'h0 << (64 - nbits);
    chk({name, "_miso"}, got, {exp_frame, 24'h0} & mask);
    chk({name, "_cmd"}, 64'(cmd_byte), 64'(exp_cmd));
    chk({name, "_led"}, 64'(led), 64'(exp_led));
    chk({name, "_valid"}, 64'(n_valid - v0), 64'(exp_valid));
    chk({name, "_err"}, 64'(n_err - e0), 64'(exp_err));
    chk({name, "_busy"}, 64'(bs), 64'(1));
    chk({name, "_miso_idle"}, 64'(MISO), 64'(0));
  endtask
  task automatic run_model(input string name, input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                           input logic [7:0] cmd, input int nbits);
    logic [63:0] got;
    logic bs;
    int v0, e0;
    x_pos = x;
    y_pos = y;
    buttons = b;
    v0 = n_valid;
    e0 = n_err;
    spi_frame(cmd, nbits, got, bs);
    if (nbits >= 40) begin
      m_cmd = cmd;
      if (cmd >= 128) m_led = 2'(cmd % 4);
    end
    check_frame(name, got, bs, v0, e0, ref_frame(x, y, b), nbits, m_cmd, m_led,
                (nbits >= 40) ? 1 : 0, (nbits < 40) ? 1 : 0);
  endtask
  initial begin
    logic [63:0] got;
    logic bs;
    int v0, e0;
    vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 40'hA5023C0105, 8'h83, 2'b11, 1, 0};
    vecs[1] = '{10'h2A5, 10'h13C, 3'b101, 8'h02, 40, 40'hA5023C0105, 8'h02, 2'b11, 1, 0};
    vecs[2] = '{10'h2A5, 10'h13C, 3'b101, 8'h81, 17, 40'hA5023C0105, 8'h02, 2'b11, 0, 1};
    vecs[3] = '{10'h155, 10'h2AA, 3'b010, 8'h81, 45, 40'h5501AA0202, 8'h81, 2'b01, 1, 0};
    vecs[4] = '{10'h155, 10'h2AA, 3'b010, 8'h80, 0, 40'h5501AA0202, 8'h81, 2'b01, 0, 1};
    vecs[5] = '{10'h3FF, 10'h000, 3'b111, 8'hC2, 40, 40'hFF03000007, 8'hC2, 2'b10, 1, 0};
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", 64'(MISO), 64'(0));
    chk("rst_led", 64'(led), 64'(0));
    chk("rst_cmd", 64'(cmd_byte), 64'(0));
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_err", 64'(frame_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (6) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      x_pos = vecs[i].x;
      y_pos = vecs[i].y;
      buttons = vecs[i].btn;
      v0 = n_valid;
      e0 = n_err;
      spi_frame(vecs[i].cmd, vecs[i].nbits, got, bs);
      check_frame($sformatf("vec%0d", i), got, bs, v0, e0, vecs[i].exp_frame, vecs[i].nbits,
                  vecs[i].exp_cmd, vecs[i].exp_led, vecs[i].exp_valid, vecs[i].exp_err);
    end
    m_cmd = 8'hC2;
    m_led = 2'b10;
    x_pos = 10'h2A5;
    y_pos = 10'h13C;
    buttons = 3'b101;
    v0 = n_valid;
    e0 = n_err;
    fork
      spi_frame(8'h01, 40, got, bs);
      begin
        repeat (H + 20 * H) @(negedge clk);
        x_pos = 10'h3FF;
      end
    join
    m_cmd = 8'h01;
    check_frame("xchg_old", got, bs, v0, e0, ref_frame(10'h2A5, 10'h13C, 3'b101), 40, m_cmd, m_led, 1, 0);
    run_model("xchg_new", 10'h3FF, 10'h13C, 3'b101, 8'h00, 40);
    v0 = n_valid;
    e0 = n_err;
    fork
      spi_frame(8'h83, 40, got, bs);
      begin
        repeat (H + 40 * H) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_miso", 64'(MISO), 64'(0));
        chk("midrst_led", 64'(led), 64'(0));
        chk("midrst_cmd", 64'(cmd_byte), 64'(0));
      end
    join
    chk("midrst_busy_end", 64'(bs), 64'(0));
    chk("midrst_valid", 64'(n_valid - v0), 64'(0));
    chk("midrst_err", 64'(n_err - e0), 64'(0));
    chk("midrst_cmd_end", 64'(cmd_byte), 64'(0));
    m_cmd = '0;
    m_led = '0;
    run_model("post_rst", 10'h2A5, 10'h13C, 3'b101, 8'h83, 40);
    for (int i = 0; i < 20; i++) begin
      int sel, nb;
      sel = $urandom_range(0, 3);
      nb = (sel == 1) ? $urandom_range(41, 48) : (sel == 2) ? $urandom_range(0, 39) : 40;
      run_model($sformatf("rnd%0d", i), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), nb);
    end
    chk("no_both_pulses", 64'(n_both), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
